// File: rtl/lsu_pkg.sv
// Shared FSM state type, funct3 encodings and access legality check for the load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    DONE,
    ERR
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned variants are load-only, so a store with them is rejected like any bad code.
  function automatic logic is_misaligned(input logic we, input logic [2:0] funct3,
                                         input logic [1:0] byte_off);
    logic bad;
    case (funct3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = byte_off[0];
      F3_W:    bad = (byte_off != 2'b00);
      F3_BU:   bad = we;
      F3_HU:   bad = we | byte_off[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts/extends load data and merges sub-word store data into a word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] mem_word,
  input  logic [31:0] store_val,
  output logic [31:0] load_val,
  output logic [31:0] merged_word
);

  logic [4:0]  byte_pos;
  logic [4:0]  half_pos;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign byte_pos = {byte_off, 3'b000};
  assign half_pos = {byte_off[1], 4'b0000};
  assign lane_b   = mem_word[byte_pos +: 8];
  assign lane_h   = mem_word[half_pos +: 16];

  always_comb begin
    load_val = mem_word;
    case (funct3)
      F3_B:    load_val = {{24{lane_b[7]}}, lane_b};
      F3_BU:   load_val = {24'b0, lane_b};
      F3_H:    load_val = {{16{lane_h[15]}}, lane_h};
      F3_HU:   load_val = {16'b0, lane_h};
      default: load_val = mem_word;
    endcase
  end

  always_comb begin
    merged_word = store_val;
    case (funct3)
      F3_B: begin
        merged_word = mem_word;
        merged_word[byte_pos +: 8] = store_val[7:0];
      end
      F3_H: begin
        merged_word = mem_word;
        merged_word[half_pos +: 16] = store_val[15:0];
      end
      default: merged_word = store_val;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: sequences byte/half/word accesses to a word-wide memory with a combinational read port.
// Sub-word stores are read-modify-write; misaligned or illegal accesses complete immediately with an error.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int address_width = 1024
) (
  input  logic                             CLK,
  input  logic                             RST_n,
  input  logic                             req,
  input  logic                             we,
  input  logic [2:0]                       funct3,
  input  logic [31:0]                      addr,
  input  logic [31:0]                      wdata,
  output logic                             done,
  output logic [31:0]                      rdata,
  output logic                             misaligned,
  output logic                             busy,
  output logic                             MemWrite,
  output logic [31:0]                      write_data,
  output logic [$clog2(address_width)-1:0] address,
  input  logic [31:0]                      read_data
);

  localparam int AW = $clog2(address_width);

  lsu_state_t  state;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic [31:0] r_wdata;
  logic [31:0] load_val;
  logic [31:0] merged_word;

  // Upper address bits beyond the memory size wrap around by design.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:AW+2];

  lsu_lane_align u_lane_align (
    .funct3     (r_funct3),
    .byte_off   (r_off),
    .mem_word   (read_data),
    .store_val  (r_wdata),
    .load_val   (load_val),
    .merged_word(merged_word)
  );

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state      <= IDLE;
      r_we       <= 1'b0;
      r_funct3   <= '0;
      r_off      <= '0;
      r_wdata    <= '0;
      done       <= 1'b0;
      misaligned <= 1'b0;
      busy       <= 1'b0;
      MemWrite   <= 1'b0;
      rdata      <= '0;
      address    <= '0;
      write_data <= '0;
    end else begin
      done       <= 1'b0;
      misaligned <= 1'b0;
      MemWrite   <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            r_we     <= we;
            r_funct3 <= funct3;
            r_off    <= addr[1:0];
            r_wdata  <= wdata;
            address  <= addr[AW+1:2];
            busy     <= 1'b1;
            if (is_misaligned(we, funct3, addr[1:0])) begin
              state      <= ERR;
              done       <= 1'b1;
              misaligned <= 1'b1;
            end else if (we && funct3 == F3_W) begin
              state      <= WRITE;
              MemWrite   <= 1'b1;
              write_data <= wdata;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          // Address is registered, so read_data here belongs to the accepted access.
          if (r_we) begin
            state      <= WRITE;
            MemWrite   <= 1'b1;
            write_data <= merged_word;
          end else begin
            state <= DONE;
            done  <= 1'b1;
            rdata <= load_val;
          end
        end
        WRITE: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE, ERR: begin
          state   <= IDLE;
          busy    <= 1'b0;
          address <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a transaction-level scoreboard checked every cycle.
module tb_load_store_unit;

  localparam int AW = 10;

  logic          CLK = 1'b0;
  logic          RST_n;
  logic          req;
  logic          we;
  logic [2:0]    funct3;
  logic [31:0]   addr;
  logic [31:0]   wdata;
  logic          done;
  logic [31:0]   rdata;
  logic          misaligned;
  logic          busy;
  logic          MemWrite;
  logic [31:0]   write_data;
  logic [AW-1:0] address;
  logic [31:0]   read_data;

  logic [31:0] mem [0:1023];

  int total_checks = 0;
  int pass_checks  = 0;
  int mw_total     = 0;

  always #5 CLK = ~CLK;

  load_store_unit #(.address_width(1024)) dut (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .req       (req),
    .we        (we),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .done      (done),
    .rdata     (rdata),
    .misaligned(misaligned),
    .busy      (busy),
    .MemWrite  (MemWrite),
    .write_data(write_data),
    .address   (address),
    .read_data (read_data)
  );

  // Attached data memory: combinational read, synchronous write.
  assign read_data = mem[address];
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[2] = 32'h11223344;
    mem[5] = 32'h8899AABB;
    mem[8] = 32'h55667788;
    forever begin
      @(posedge CLK);
      if (MemWrite) mem[address] <= write_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act === exp) pass_checks++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic          done;
    logic          mis;
    logic          busy;
    logic          mw;
    logic [AW-1:0] adr;
    logic [31:0]   wd;
    logic [31:0]   rd;
  } exp_t;

  function automatic exp_t ent(input logic d, input logic m, input logic b, input logic w,
                               input logic [AW-1:0] a, input logic [31:0] wd, input logic [31:0] rd);
    exp_t e;
    e.done = d; e.mis = m; e.busy = b; e.mw = w; e.adr = a; e.wd = wd; e.rd = rd;
    return e;
  endfunction

  function automatic logic bad_access(input logic w, input logic [2:0] f, input logic [31:0] a);
    logic [2:0] fv;
    int size;
    logic legal;
    fv = f;
    legal = (fv == 3'd0 || fv == 3'd1 || fv == 3'd2 || fv == 3'd4 || fv == 3'd5) && !(w && fv >= 3'd4);
    size = 1 << fv[1:0];
    return !legal || ((a % size) != 0);
  endfunction

  function automatic logic [31:0] load_model(input logic [31:0] word, input logic [2:0] f,
                                             input logic [1:0] off);
    logic [31:0] v;
    v = word >> (8 * off);
    case (f)
      3'd0: begin v = v & 32'hFF;   if (v >= 32'd128)   v = v | 32'hFFFFFF00; end
      3'd4: v = v & 32'hFF;
      3'd1: begin v = v & 32'hFFFF; if (v >= 32'd32768) v = v | 32'hFFFF0000; end
      3'd5: v = v & 32'hFFFF;
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] merge_model(input logic [31:0] word, input logic [2:0] f,
                                              input logic [1:0] off, input logic [31:0] wd);
    logic [31:0] mask;
    mask = (f == 3'd0) ? 32'hFF : 32'hFFFF;
    return (word & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
  endfunction

  // Model advances on rising edges, compares DUT on falling edges.
  initial begin
    exp_t        q[$];
    exp_t        e;
    logic [31:0] ref_mem [0:1023];
    logic [31:0] m_rdata;
    logic        model_on;
    logic [AW-1:0] idx;
    logic [31:0] v;
    m_rdata  = 32'h0;
    model_on = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    ref_mem[2] = 32'h11223344;
    ref_mem[5] = 32'h8899AABB;
    ref_mem[8] = 32'h55667788;
    forever begin
      @(posedge CLK);
      if (!RST_n) begin
        q.delete();
        m_rdata  = 32'h0;
        model_on = 1'b1;
      end else if (model_on && q.size() == 0 && req) begin
        idx = addr[AW+1:2];
        if (bad_access(we, funct3, addr)) begin
          q.push_back(ent(1, 1, 1, 0, idx, 0, m_rdata));
        end else if (!we) begin
          v = load_model(ref_mem[idx], funct3, addr[1:0]);
          q.push_back(ent(0, 0, 1, 0, idx, 0, m_rdata));
          q.push_back(ent(1, 0, 1, 0, idx, 0, v));
          m_rdata = v;
        end else if (funct3 == 3'd2) begin
          q.push_back(ent(0, 0, 1, 1, idx, wdata, m_rdata));
          q.push_back(ent(1, 0, 1, 0, idx, 0, m_rdata));
        end else begin
          v = merge_model(ref_mem[idx], funct3, addr[1:0], wdata);
          q.push_back(ent(0, 0, 1, 0, idx, 0, m_rdata));
          q.push_back(ent(0, 0, 1, 1, idx, v, m_rdata));
          q.push_back(ent(1, 0, 1, 0, idx, 0, m_rdata));
        end
        if (q.size() != 0) q.push_back(ent(0, 0, 0, 0, 0, 0, m_rdata));
      end
      @(negedge CLK);
      if (model_on) begin
        e = (q.size() != 0) ? q.pop_front() : ent(0, 0, 0, 0, 0, 0, m_rdata);
        chk($sformatf("t=%0t done", $time), {31'b0, done}, {31'b0, e.done});
        chk($sformatf("t=%0t misaligned", $time), {31'b0, misaligned}, {31'b0, e.mis});
        chk($sformatf("t=%0t busy", $time), {31'b0, busy}, {31'b0, e.busy});
        chk($sformatf("t=%0t MemWrite", $time), {31'b0, MemWrite}, {31'b0, e.mw});
        chk($sformatf("t=%0t address", $time), 32'(address), 32'(e.adr));
        chk($sformatf("t=%0t rdata", $time), rdata, e.rd);
        if (e.mw) begin
          chk($sformatf("t=%0t write_data", $time), write_data, e.wd);
          ref_mem[e.adr] = e.wd;
        end
        if (MemWrite) mw_total++;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic run(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                     output int lat, output logic [31:0] rd, output logic mis,
                     output int mwc, output logic [31:0] mwa, output logic [31:0] mwd);
    lat = 0; rd = 'x; mis = 'x; mwc = 0; mwa = 'x; mwd = 'x;
    @(negedge CLK);
    req = 1'b1; we = w; funct3 = f; addr = a; wdata = d;
    @(posedge CLK);
    lat = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (i == 0) begin
        req = 1'b0; we = ~w; funct3 = 3'b111; addr = 32'hFFFF_FFFF; wdata = $urandom;
      end
      if (MemWrite) begin
        mwc++; mwa = 32'(address); mwd = write_data;
      end
      if (done) begin
        rd = rdata; mis = misaligned;
        break;
      end
      @(posedge CLK);
      lat++;
    end
  endtask

  typedef struct packed {
    logic        w;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] d;
  } vec_t;

  initial begin
    int lat, mwc, mw_before, dones;
    logic [31:0] rd, mwa, mwd;
    logic mis;
    vec_t vecs[6];

    RST_n = 1'b0; req = 1'b0; we = 1'b0; funct3 = 3'b0; addr = 32'h0; wdata = 32'h0;
    repeat (2) @(negedge CLK);
    chk("reset done", {31'b0, done}, 32'h0);
    chk("reset busy", {31'b0, busy}, 32'h0);
    chk("reset MemWrite", {31'b0, MemWrite}, 32'h0);
    chk("reset misaligned", {31'b0, misaligned}, 32'h0);
    chk("reset rdata", rdata, 32'h0);
    chk("reset address", 32'(address), 32'h0);
    chk("reset write_data", write_data, 32'h0);
    RST_n = 1'b1;

    run(0, 3'b000, 32'h16, 0, lat, rd, mis, mwc, mwa, mwd);
    chk("LB latency", lat, 2);
    chk("LB rdata", rd, 32'hFFFFFF99);
    chk("LB misaligned", {31'b0, mis}, 32'h0);
    run(0, 3'b100, 32'h16, 0, lat, rd, mis, mwc, mwa, mwd);
    chk("LBU rdata", rd, 32'h00000099);
    run(0, 3'b001, 32'h16, 0, lat, rd, mis, mwc, mwa, mwd);
    chk("LH rdata", rd, 32'hFFFF8899);
    run(0, 3'b101, 32'h14, 0, lat, rd, mis, mwc, mwa, mwd);
    chk("LHU rdata", rd, 32'h0000AABB);

    run(1, 3'b001, 32'h0A, 32'h0000BEEF, lat, rd, mis, mwc, mwa, mwd);
    chk("SH latency", lat, 3);
    chk("SH MemWrite count", mwc, 1);
    chk("SH address", mwa, 32'd2);
    chk("SH write_data", mwd, 32'hBEEF3344);
    chk("SH rdata kept", rd, 32'h0000AABB);
    run(1, 3'b000, 32'h0B, 32'h00000123, lat, rd, mis, mwc, mwa, mwd);
    chk("SB latency", lat, 3);
    chk("SB write_data", mwd, 32'h23EF3344);

    run(1, 3'b010, 32'h10, 32'hDEADBEEF, lat, rd, mis, mwc, mwa, mwd);
    chk("SW latency", lat, 2);
    chk("SW MemWrite count", mwc, 1);
    chk("SW address", mwa, 32'd4);
    chk("SW write_data", mwd, 32'hDEADBEEF);
    run(0, 3'b010, 32'h10, 0, lat, rd, mis, mwc, mwa, mwd);
    chk("LW after SW", rd, 32'hDEADBEEF);
    run(0, 3'b010, 32'h1010, 0, lat, rd, mis, mwc, mwa, mwd);
    chk("LW wrapped addr", rd, 32'hDEADBEEF);

    run(0, 3'b010, 32'h03, 0, lat, rd, mis, mwc, mwa, mwd);
    chk("misaligned LW latency", lat, 1);
    chk("misaligned LW flag", {31'b0, mis}, 32'h1);
    chk("misaligned LW MemWrite", mwc, 0);
    chk("misaligned LW rdata kept", rd, 32'hDEADBEEF);
    run(1, 3'b100, 32'h10, 32'h1, lat, rd, mis, mwc, mwa, mwd);
    chk("store with LBU code flag", {31'b0, mis}, 32'h1);
    chk("store with LBU code MemWrite", mwc, 0);
    run(0, 3'b010, 32'h08, 0, lat, rd, mis, mwc, mwa, mwd);
    chk("LW merged word", rd, 32'h23EF3344);

    // Reset while a byte store sits in READ.
    @(negedge CLK);
    mw_before = mw_total;
    req = 1'b1; we = 1'b1; funct3 = 3'b000; addr = 32'h20; wdata = 32'hA5;
    @(negedge CLK);
    chk("SB busy before reset", {31'b0, busy}, 32'h1);
    req = 1'b0; RST_n = 1'b0;
    @(negedge CLK);
    chk("abort busy", {31'b0, busy}, 32'h0);
    chk("abort done", {31'b0, done}, 32'h0);
    RST_n = 1'b1;
    repeat (4) @(negedge CLK);
    chk("abort no MemWrite", mw_total, mw_before);
    chk("abort memory intact", mem[8], 32'h55667788);

    // req held high; only edges 1, 4, 7 find the unit idle, other cycles present junk.
    dones = 0;
    for (int e = 1; e <= 9; e++) begin
      @(negedge CLK);
      if (done) begin
        dones++;
        chk("held-req LW rdata", rdata, 32'hDEADBEEF);
      end
      req = 1'b1;
      if (e == 1 || e == 4 || e == 7) begin
        we = 1'b0; funct3 = 3'b010; addr = 32'h10; wdata = 32'h0;
      end else begin
        we = 1'b1; funct3 = 3'b111; addr = 32'h3; wdata = $urandom;
      end
    end
    @(negedge CLK);
    req = 1'b0;
    chk("held-req done count", dones, 3);

    vecs[0] = '{w: 1'b0, f: 3'b010, a: 32'h10, d: 32'h0};
    vecs[1] = '{w: 1'b1, f: 3'b000, a: 32'h21, d: 32'h5A};
    vecs[2] = '{w: 1'b0, f: 3'b001, a: 32'h0A, d: 32'h0};
    vecs[3] = '{w: 1'b1, f: 3'b001, a: 32'h23, d: 32'h77};
    vecs[4] = '{w: 1'b1, f: 3'b010, a: 32'h24, d: 32'h12345678};
    vecs[5] = '{w: 1'b0, f: 3'b100, a: 32'h21, d: 32'h0};
    for (int c = 0; c < 30; c++) begin
      @(negedge CLK);
      req = 1'b1;
      we = vecs[c % 6].w; funct3 = vecs[c % 6].f; addr = vecs[c % 6].a; wdata = vecs[c % 6].d;
    end
    @(negedge CLK);
    req = 1'b0;
    repeat (6) @(negedge CLK);

    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
